painel_torradeira: RTL and testbench
====================================

PAINEL_TORRADEIRA -- requirements
Module: painel_torradeira

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1_000_000, consecutive stable samples required to accept a key level (20 ms at 50 MHz).
REQ-002 Parameter DEFAULT_TEMPO, default 5, preset seconds after reset.
REQ-003 Parameter MAX_TEMPO, default 9, upper saturation limit of the preset.
REQ-004 CLOCK_50  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 KEY_UP, KEY_DOWN, KEY_START, KEY_CANCEL  in  1 each  raw asynchronous push-buttons, active-low (0 = pressed).
REQ-007 done  in  1  countdown timer finished, level, sampled synchronously.
REQ-008 tempo_cfg  out  4  preset cook time in seconds, range 1..MAX_TEMPO, unsigned.
REQ-009 start  out  1  one-cycle pulse commanding the timer to load tempo_cfg and run.
REQ-010 abort  out  1  one-cycle pulse commanding the timer to stop.
REQ-011 heater  out  1  heating element enable, high only in RUNNING.
REQ-012 estado  out  2  FSM state code: IDLE=0, RUNNING=1, DONE=2.
REQ-013 HEX_TEMPO  out  7  seven-segment pattern of tempo_cfg, active-low segments.

Function
REQ-014 Each key SHALL pass a 2-flop synchronizer, then a per-key debounce counter; the debounced level changes only after DEBOUNCE_CYCLES consecutive equal synchronized samples differing from it; any mismatch clears the counter.
REQ-015 A press event SHALL be a one-cycle pulse on the debounced 1->0 transition; releases generate no event; a held key generates exactly one event.
REQ-016 Latency from a clean key edge to its press event SHALL be 2 + DEBOUNCE_CYCLES cycles (+/-1).
REQ-017 IDLE: UP event increments tempo_cfg saturating at MAX_TEMPO; DOWN event decrements saturating at 1; UP and DOWN in the same cycle leave tempo_cfg unchanged.
REQ-018 IDLE: START event SHALL pulse start for one cycle and enter RUNNING next cycle; UP/DOWN in that same cycle are ignored; tempo_cfg is frozen from then until return to IDLE.
REQ-019 IDLE: CANCEL and done SHALL be ignored.
REQ-020 RUNNING: heater=1; UP, DOWN, START ignored; CANCEL event pulses abort one cycle and returns to IDLE; done=1 enters DONE without abort.
REQ-021 RUNNING: done=1 and CANCEL event in the same cycle SHALL give DONE, no abort pulse (completion wins).
REQ-022 DONE: heater=0; any press event of any key returns to IDLE; that event has no other effect (no preset change, no start).
REQ-023 heater SHALL be a registered output equal to (estado==RUNNING); start and abort SHALL be registered and never both high.
REQ-024 HEX_TEMPO SHALL be combinational from tempo_cfg via the codebase's existing seven-segment decoder.

Reset
REQ-025 reset=1 at a clock edge SHALL force: estado=IDLE, tempo_cfg=DEFAULT_TEMPO, start=0, abort=0, heater=0, debounced levels=released (1), debounce counters=0, synchronizers=1.
REQ-026 Reset during RUNNING SHALL drop heater the next edge and SHALL NOT emit abort; a key held through reset produces no event after reset until released and pressed again.

Structure
REQ-027 State encodings (IDLE, RUNNING, DONE) and tempo limits SHALL live in a shared torradeira package/include used by this block and the timer.
REQ-028 Synchronizer + debounce + edge detect SHALL be one sub-module, debounce_tecla, instantiated four times.
REQ-029 Expected size: 150-300 lines RTL total.

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-030 Reset, then 3 clean UP presses -> tempo_cfg 5->6->7->8, HEX_TEMPO shows 8; 6 more UP presses -> stays 9.
REQ-031 KEY_DOWN bouncing 0/1 every 2 cycles for 20 cycles then stable 0 -> exactly one DOWN event, tempo_cfg decrements by 1; repeat from 1 -> stays 1.
REQ-032 START in IDLE with tempo_cfg=5 -> start high exactly 1 cycle, estado=1, heater=1; UP during RUNNING -> tempo_cfg stays 5; done=1 -> estado=2, heater=0, no abort.
REQ-033 RUNNING, CANCEL press -> abort 1-cycle pulse, estado=0, heater=0; RUNNING with done=1 and CANCEL event same cycle -> estado=2, abort stays 0.
REQ-034 DONE, UP press -> estado=0, tempo_cfg unchanged; then START -> new start pulse.
REQ-035 reset asserted in RUNNING with KEY_START held -> heater=0 next edge, abort=0, tempo_cfg=5, no start until KEY_START released and re-pressed.

Source files
------------

// File: rtl/painel_torradeira_pkg.sv
// Shared toaster definitions: FSM state codes, preset limits and the
// seven-segment decoder used by the control panel and the countdown timer.
package painel_torradeira_pkg;

  // State codes are visible on the panel output and decoded by the timer.
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRunning = 2'd1,
    StDone    = 2'd2
  } estado_e;

  localparam int unsigned TempoW       = 4;
  localparam int unsigned TempoMin     = 1;
  localparam int unsigned TempoMax     = 9;
  localparam int unsigned TempoDefault = 5;

  // Active-low segments, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7seg(input logic [3:0] v);
    logic [6:0] seg;
    case (v)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/painel_torradeira_if.sv
// Panel <-> countdown timer link.
//   tempo_cfg : preset seconds, loaded by the timer on start
//   start     : one-cycle pulse, load tempo_cfg and run
//   abort     : one-cycle pulse, stop the countdown
//   done      : level from the timer, countdown finished
interface painel_torradeira_if;
  import painel_torradeira_pkg::*;

  logic [TempoW-1:0] tempo_cfg;
  logic              start;
  logic              abort;
  logic              done;

  modport master (output tempo_cfg, output start, output abort, input done);
  modport slave  (input tempo_cfg, input start, input abort, output done);
endinterface

// File: rtl/debounce_tecla.sv
// One push-button front end: 2-flop synchronizer, debounce counter and a
// press pulse on the debounced 1->0 transition.
//   clk_i   : clock
//   rst_i   : synchronous active-high reset
//   key_ni  : raw asynchronous button, active-low
//   press_o : one-cycle registered pulse per accepted press
module debounce_tecla #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_ni,
  output logic press_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_q, sync_d;
  logic            level_q, level_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  // Arming: a key held through reset must be released before it can fire,
  // so events are enabled only after a debounced released level is seen.
  logic [CntW-1:0] arm_cnt_q, arm_cnt_d;
  logic            armed_q, armed_d;
  logic            press_q, press_d;

  always_comb begin
    sync_d    = {sync_q[0], key_ni};
    level_d   = level_q;
    cnt_d     = '0;
    arm_cnt_d = '0;
    armed_d   = armed_q;
    press_d   = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CntLast) begin
        level_d = sync_q[1];
        if (!sync_q[1]) press_d = armed_q;
        else            armed_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (!armed_q && sync_q[1]) begin
      if (arm_cnt_q == CntLast) armed_d = 1'b1;
      else                      arm_cnt_d = arm_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q    <= 2'b11;
      level_q   <= 1'b1;
      cnt_q     <= '0;
      arm_cnt_q <= '0;
      armed_q   <= 1'b0;
      press_q   <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      level_q   <= level_d;
      cnt_q     <= cnt_d;
      arm_cnt_q <= arm_cnt_d;
      armed_q   <= armed_d;
      press_q   <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/painel_torradeira.sv
// Toaster control panel: debounced keys set the preset, start/cancel the
// cook cycle and drive the heater and the timer handshake.
//   CLOCK_50, reset  : clock, synchronous active-high reset
//   KEY_*            : raw active-low push-buttons
//   tmr              : timer link (tempo_cfg, start, abort out; done in)
//   heater           : heating element, high only while running
//   estado           : state code (0 idle, 1 running, 2 done)
//   HEX_TEMPO        : active-low seven-segment view of tempo_cfg
module painel_torradeira
  import painel_torradeira_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned DEFAULT_TEMPO   = TempoDefault,
  parameter int unsigned MAX_TEMPO       = TempoMax
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic                 KEY_UP,
  input  logic                 KEY_DOWN,
  input  logic                 KEY_START,
  input  logic                 KEY_CANCEL,
  painel_torradeira_if.master  tmr,
  output logic                 heater,
  output logic [1:0]           estado,
  output logic [6:0]           HEX_TEMPO
);

  localparam logic [TempoW-1:0] TempoDef = TempoW'(DEFAULT_TEMPO);
  localparam logic [TempoW-1:0] TempoHi  = TempoW'(MAX_TEMPO);
  localparam logic [TempoW-1:0] TempoLo  = TempoW'(TempoMin);

  logic [3:0] keys_n;
  logic [3:0] ev;  // {cancel, start, down, up}

  assign keys_n = {KEY_CANCEL, KEY_START, KEY_DOWN, KEY_UP};

  for (genvar i = 0; i < 4; i++) begin : g_key
    debounce_tecla #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk_i  (CLOCK_50),
      .rst_i  (reset),
      .key_ni (keys_n[i]),
      .press_o(ev[i])
    );
  end

  logic ev_up, ev_down, ev_start, ev_cancel;
  assign ev_up     = ev[0];
  assign ev_down   = ev[1];
  assign ev_start  = ev[2];
  assign ev_cancel = ev[3];

  estado_e           state_q;
  logic [TempoW-1:0] tempo_q;
  logic              start_q, abort_q, heater_q;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= StIdle;
      tempo_q  <= TempoDef;
      start_q  <= 1'b0;
      abort_q  <= 1'b0;
      heater_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      abort_q <= 1'b0;
      case (state_q)
        StIdle: begin
          // START takes priority; simultaneous UP/DOWN cancel each other.
          if (ev_start) begin
            start_q  <= 1'b1;
            heater_q <= 1'b1;
            state_q  <= StRunning;
          end else if (ev_up && !ev_down) begin
            if (tempo_q < TempoHi) tempo_q <= tempo_q + 1'b1;
          end else if (ev_down && !ev_up) begin
            if (tempo_q > TempoLo) tempo_q <= tempo_q - 1'b1;
          end
        end
        StRunning: begin
          // Completion wins over a same-cycle cancel.
          if (tmr.done) begin
            heater_q <= 1'b0;
            state_q  <= StDone;
          end else if (ev_cancel) begin
            abort_q  <= 1'b1;
            heater_q <= 1'b0;
            state_q  <= StIdle;
          end
        end
        StDone: begin
          if (|ev) state_q <= StIdle;
        end
        default: begin
          heater_q <= 1'b0;
          state_q  <= StIdle;
        end
      endcase
    end
  end

  assign tmr.tempo_cfg = tempo_q;
  assign tmr.start     = start_q;
  assign tmr.abort     = abort_q;
  assign heater        = heater_q;
  assign estado        = state_q;
  assign HEX_TEMPO     = hex7seg(tempo_q);

endmodule

// File: tb/tb_painel_torradeira.sv
module tb_painel_torradeira;

  localparam int unsigned Deb = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] keys_n = 4'hF;  // {cancel, start, down, up}
  logic       heater;
  logic [1:0] estado;
  logic [6:0] hex;

  int n_tests = 0;
  int n_fail  = 0;

  // Pulse monitors, sampled on the falling edge.
  int   start_cnt = 0, abort_cnt = 0, start_long = 0, abort_long = 0, both_cnt = 0;
  logic start_prev = 1'b0, abort_prev = 1'b0;

  painel_torradeira_if tmr_if ();

  painel_torradeira #(
    .DEBOUNCE_CYCLES(Deb),
    .DEFAULT_TEMPO  (5),
    .MAX_TEMPO      (9)
  ) dut (
    .CLOCK_50  (clk),
    .reset     (rst),
    .KEY_UP    (keys_n[0]),
    .KEY_DOWN  (keys_n[1]),
    .KEY_START (keys_n[2]),
    .KEY_CANCEL(keys_n[3]),
    .tmr       (tmr_if),
    .heater    (heater),
    .estado    (estado),
    .HEX_TEMPO (hex)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tmr_if.start) start_cnt++;
    if (tmr_if.abort) abort_cnt++;
    if (tmr_if.start && start_prev) start_long++;
    if (tmr_if.abort && abort_prev) abort_long++;
    if (tmr_if.start && tmr_if.abort) both_cnt++;
    start_prev = tmr_if.start;
    abort_prev = tmr_if.abort;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_key(input int k);
    keys_n[k] = 1'b0;
    cyc(10);
    keys_n[k] = 1'b1;
    cyc(10);
  endtask

  task automatic test_reset;
    tmr_if.done = 1'b0;
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(8);
    n_tests++; if (estado !== 2'd0) begin n_fail++; $display("FAIL reset_estado got %0d exp 0", estado); end
    n_tests++; if (tmr_if.tempo_cfg !== 4'd5) begin n_fail++; $display("FAIL reset_tempo got %0d exp 5", tmr_if.tempo_cfg); end
    n_tests++; if (heater !== 1'b0 || tmr_if.start !== 1'b0 || tmr_if.abort !== 1'b0) begin
      n_fail++; $display("FAIL reset_outs got h%b s%b a%b exp 000", heater, tmr_if.start, tmr_if.abort); end
    n_tests++; if (hex !== 7'b0010010) begin n_fail++; $display("FAIL reset_hex got %b exp 0010010", hex); end
  endtask

  task automatic test_up;
    logic [3:0] exp_t [3] = '{4'd6, 4'd7, 4'd8};
    for (int i = 0; i < 3; i++) begin
      press_key(0);
      n_tests++; if (tmr_if.tempo_cfg !== exp_t[i]) begin
        n_fail++; $display("FAIL up_step%0d got %0d exp %0d", i, tmr_if.tempo_cfg, exp_t[i]); end
    end
    n_tests++; if (hex !== 7'b0000000) begin n_fail++; $display("FAIL up_hex8 got %b exp 0000000", hex); end
    for (int i = 0; i < 6; i++) press_key(0);
    n_tests++; if (tmr_if.tempo_cfg !== 4'd9) begin n_fail++; $display("FAIL up_sat got %0d exp 9", tmr_if.tempo_cfg); end
    n_tests++; if (hex !== 7'b0010000) begin n_fail++; $display("FAIL up_hex9 got %b exp 0010000", hex); end
  endtask

  task automatic bounce_down;
    for (int i = 0; i < 5; i++) begin
      keys_n[1] = 1'b0; cyc(2);
      keys_n[1] = 1'b1; cyc(2);
    end
  endtask

  task automatic test_down_bounce;
    bounce_down();
    n_tests++; if (tmr_if.tempo_cfg !== 4'd9) begin n_fail++; $display("FAIL bounce_noevent got %0d exp 9", tmr_if.tempo_cfg); end
    keys_n[1] = 1'b0; cyc(12);
    keys_n[1] = 1'b1; cyc(10);
    n_tests++; if (tmr_if.tempo_cfg !== 4'd8) begin n_fail++; $display("FAIL bounce_one got %0d exp 8", tmr_if.tempo_cfg); end
    for (int i = 0; i < 7; i++) press_key(1);
    n_tests++; if (tmr_if.tempo_cfg !== 4'd1) begin n_fail++; $display("FAIL down_to1 got %0d exp 1", tmr_if.tempo_cfg); end
    bounce_down();
    keys_n[1] = 1'b0; cyc(12);
    keys_n[1] = 1'b1; cyc(10);
    n_tests++; if (tmr_if.tempo_cfg !== 4'd1) begin n_fail++; $display("FAIL down_sat got %0d exp 1", tmr_if.tempo_cfg); end
  endtask

  // Event appears 2+Deb edges after the key edge, the preset one edge later.
  task automatic test_latency;
    keys_n[0] = 1'b0;
    cyc(2 + Deb);
    n_tests++; if (tmr_if.tempo_cfg !== 4'd1) begin n_fail++; $display("FAIL lat_early got %0d exp 1", tmr_if.tempo_cfg); end
    cyc(1);
    n_tests++; if (tmr_if.tempo_cfg !== 4'd2) begin n_fail++; $display("FAIL lat_on_time got %0d exp 2", tmr_if.tempo_cfg); end
    cyc(10);
    keys_n[0] = 1'b1;
    cyc(10);
    n_tests++; if (tmr_if.tempo_cfg !== 4'd2) begin n_fail++; $display("FAIL lat_held got %0d exp 2", tmr_if.tempo_cfg); end
  endtask

  task automatic test_up_down_same;
    keys_n[1:0] = 2'b00; cyc(10);
    keys_n[1:0] = 2'b11; cyc(10);
    n_tests++; if (tmr_if.tempo_cfg !== 4'd2) begin n_fail++; $display("FAIL updown_same got %0d exp 2", tmr_if.tempo_cfg); end
    for (int i = 0; i < 3; i++) press_key(0);
  endtask

  task automatic test_idle_ignore;
    int a0 = abort_cnt;
    press_key(3);
    tmr_if.done = 1'b1; cyc(3); tmr_if.done = 1'b0; cyc(1);
    n_tests++; if (estado !== 2'd0 || abort_cnt - a0 !== 0 || tmr_if.tempo_cfg !== 4'd5) begin
      n_fail++; $display("FAIL idle_ignore got st%0d ab%0d t%0d exp st0 ab0 t5", estado, abort_cnt - a0, tmr_if.tempo_cfg); end
  endtask

  task automatic test_start;
    int s0 = start_cnt, a0 = abort_cnt, l0 = start_long;
    keys_n[2] = 1'b0; cyc(10);
    n_tests++; if (start_cnt - s0 !== 1 || start_long - l0 !== 0) begin
      n_fail++; $display("FAIL start_pulse got n%0d long%0d exp n1 long0", start_cnt - s0, start_long - l0); end
    n_tests++; if (estado !== 2'd1 || heater !== 1'b1) begin
      n_fail++; $display("FAIL start_run got st%0d h%b exp st1 h1", estado, heater); end
    keys_n[2] = 1'b1; cyc(10);
    press_key(0);
    n_tests++; if (tmr_if.tempo_cfg !== 4'd5 || estado !== 2'd1) begin
      n_fail++; $display("FAIL run_up_frozen got t%0d st%0d exp t5 st1", tmr_if.tempo_cfg, estado); end
    tmr_if.done = 1'b1; cyc(1); tmr_if.done = 1'b0;
    n_tests++; if (estado !== 2'd2 || heater !== 1'b0 || abort_cnt - a0 !== 0) begin
      n_fail++; $display("FAIL run_done got st%0d h%b ab%0d exp st2 h0 ab0", estado, heater, abort_cnt - a0); end
  endtask

  task automatic test_done_exit;
    int s0 = start_cnt;
    press_key(0);
    n_tests++; if (estado !== 2'd0 || tmr_if.tempo_cfg !== 4'd5 || start_cnt - s0 !== 0) begin
      n_fail++; $display("FAIL done_exit got st%0d t%0d s%0d exp st0 t5 s0", estado, tmr_if.tempo_cfg, start_cnt - s0); end
    press_key(2);
    n_tests++; if (start_cnt - s0 !== 1 || estado !== 2'd1) begin
      n_fail++; $display("FAIL restart got s%0d st%0d exp s1 st1", start_cnt - s0, estado); end
  endtask

  task automatic test_cancel;
    int a0 = abort_cnt, l0 = abort_long;
    press_key(3);
    n_tests++; if (abort_cnt - a0 !== 1 || abort_long - l0 !== 0) begin
      n_fail++; $display("FAIL cancel_abort got n%0d long%0d exp n1 long0", abort_cnt - a0, abort_long - l0); end
    n_tests++; if (estado !== 2'd0 || heater !== 1'b0) begin
      n_fail++; $display("FAIL cancel_idle got st%0d h%b exp st0 h0", estado, heater); end
  endtask

  task automatic test_done_cancel_same;
    int a0;
    press_key(2);
    a0 = abort_cnt;
    keys_n[3] = 1'b0;
    cyc(2 + Deb);
    tmr_if.done = 1'b1;  // coincides with the cancel event cycle
    cyc(1);
    tmr_if.done = 1'b0;
    n_tests++; if (estado !== 2'd2 || abort_cnt - a0 !== 0 || heater !== 1'b0) begin
      n_fail++; $display("FAIL done_wins got st%0d ab%0d h%b exp st2 ab0 h0", estado, abort_cnt - a0, heater); end
    cyc(4);
    keys_n[3] = 1'b1; cyc(10);
    n_tests++; if (estado !== 2'd2) begin n_fail++; $display("FAIL release_noevent got %0d exp 2", estado); end
    press_key(0);
  endtask

  task automatic test_reset_running;
    int a0, s0;
    keys_n[2] = 1'b0; cyc(10);
    a0 = abort_cnt; s0 = start_cnt;
    rst = 1'b1; cyc(1);
    n_tests++; if (heater !== 1'b0 || estado !== 2'd0 || tmr_if.tempo_cfg !== 4'd5) begin
      n_fail++; $display("FAIL rst_run got h%b st%0d t%0d exp h0 st0 t5", heater, estado, tmr_if.tempo_cfg); end
    cyc(1); rst = 1'b0;
    cyc(20);
    n_tests++; if (start_cnt - s0 !== 0 || abort_cnt - a0 !== 0 || estado !== 2'd0) begin
      n_fail++; $display("FAIL rst_held got s%0d ab%0d st%0d exp s0 ab0 st0", start_cnt - s0, abort_cnt - a0, estado); end
    keys_n[2] = 1'b1; cyc(10);
    n_tests++; if (start_cnt - s0 !== 0) begin n_fail++; $display("FAIL rst_release got %0d exp 0", start_cnt - s0); end
    press_key(2);
    n_tests++; if (start_cnt - s0 !== 1 || estado !== 2'd1) begin
      n_fail++; $display("FAIL rst_repress got s%0d st%0d exp s1 st1", start_cnt - s0, estado); end
    n_tests++; if (both_cnt !== 0) begin n_fail++; $display("FAIL start_abort_both got %0d exp 0", both_cnt); end
  endtask

  initial begin
    tmr_if.done = 1'b0;
    test_reset();
    test_up();
    test_down_bounce();
    test_latency();
    test_up_down_same();
    test_idle_ignore();
    test_start();
    test_done_exit();
    test_cancel();
    test_done_cancel_same();
    test_reset_running();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
